// File: rtl/imem_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : imem_loader_pkg
// Brief    : Shared types, constants and helpers for the instruction-memory loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    localparam int LEN_BYTES = 2;

    // Image length must fit the memory and be a whole number of 32-bit words.
    function automatic logic len_legal(input logic [LEN_BYTES*8-1:0] n,
                                       input logic [LEN_BYTES*8-1:0] max_bytes);
        return (n <= max_bytes) && (n[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
//------------------------------------------------------------------------------
// Module   : imem_loader_if
// Brief    : Byte-stream input and memory byte-write port of the loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 64
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module   : imem_loader
// Brief    : Loads a length/payload/XOR-checksum framed byte stream into
//            instruction memory and holds the core until a clean image lands.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 88,
    parameter int ADDR_W    = 64
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          core_hold
);

    localparam int                   c_len_w     = LEN_BYTES * 8;
    localparam logic [c_len_w-1:0]   c_mem_bytes = c_len_w'(MEM_BYTES);

    loader_state_t        r_state;
    logic [c_len_w-1:0]   r_len;
    logic [c_len_w-1:0]   r_addr;
    logic [7:0]           r_xor;
    logic                 r_wr_en;
    logic [c_len_w-1:0]   r_wr_addr;
    logic [7:0]           r_wr_data;
    logic                 r_done;
    logic                 r_error;
    logic                 r_core_hold;

    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_start_ok;
    logic [c_len_w-1:0]   w_len;

    always_comb begin
        w_ready    = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                     (r_state == DATA)   || (r_state == CHECK);
        w_xfer     = bus.byte_valid & w_ready;
        w_start_ok = start & ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
        w_len      = {bus.byte_data, r_len[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_xor       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_core_hold <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_state     <= LEN_LO;
                r_addr      <= '0;
                r_xor       <= '0;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
                r_core_hold <= 1'b1;
            end else if (w_xfer) begin
                case (r_state)
                    LEN_LO: begin
                        r_len[7:0] <= bus.byte_data;
                        r_state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        r_len <= w_len;
                        if (!len_legal(w_len, c_mem_bytes)) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else if (w_len == '0) begin
                            r_state <= CHECK;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= bus.byte_data;
                        r_xor     <= r_xor ^ bus.byte_data;
                        r_addr    <= r_addr + 1'b1;
                        if (r_addr == r_len - 1'b1) begin
                            r_state <= CHECK;
                        end
                    end
                    CHECK: begin
                        // Hold is released only on a clean image; a bad one keeps the core parked.
                        if (bus.byte_data == r_xor) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = ADDR_W'(r_wr_addr);
    assign bus.wr_data    = r_wr_data;
    assign busy           = w_ready;
    assign done           = r_done;
    assign error          = r_error;
    assign core_hold      = r_core_hold;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_loader
// Brief    : Randomized self-checking bench for imem_loader against a frame-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

    localparam int MEM_BYTES = 88;
    localparam int ADDR_W    = 64;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, error, core_hold;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Frame-level model: the loader consumes header+payload+checksum when the
    // length is legal, only the header otherwise.
    logic [7:0] pay[$];
    logic [7:0] frame[$];
    logic [7:0] next_frame[$];
    int         total, next_total, m_len, next_len, consumed;
    bit         m_legal, next_legal, m_ok, next_ok;
    bit         armed, m_done, m_error, m_hold;
    bit         chk_en, after_reset, exp_wr;
    int         exp_addr;
    logic [7:0] exp_data;
    logic [7:0] mem [0:MEM_BYTES-1];

    function automatic bit m_busy();
        return armed && (consumed < total);
    endfunction

    task automatic prepare(input int n, input logic [7:0] chk);
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        next_frame = {};
        next_frame.push_back(8'(n));
        next_frame.push_back(8'(n >> 8));
        foreach (pay[i]) next_frame.push_back(pay[i]);
        next_frame.push_back(chk);
        next_len   = n;
        next_legal = (n <= MEM_BYTES) && (n % 4 == 0);
        next_total = next_legal ? n + 3 : 2;
        next_ok    = next_legal && (x == chk);
    endtask

    task automatic step(input bit do_start, input bit do_reset, input int pct);
        bit rdy;
        @(negedge clk);
        if (chk_en) begin
            check_eq("wr_en", 64'(bus.wr_en), 64'(exp_wr));
            if (exp_wr) begin
                check_eq("wr_addr", bus.wr_addr, 64'(exp_addr));
                check_eq("wr_data", 64'(bus.wr_data), 64'(exp_data));
                if (exp_addr < MEM_BYTES) mem[exp_addr] = bus.wr_data;
            end
            check_eq("byte_ready", 64'(bus.byte_ready), 64'(m_busy()));
            check_eq("busy", 64'(busy), 64'(m_busy()));
            check_eq("done", 64'(done), 64'(m_done));
            check_eq("error", 64'(error), 64'(m_error));
            check_eq("core_hold", 64'(core_hold), 64'(m_hold));
            if (after_reset) begin
                check_eq("rst_wr_addr", bus.wr_addr, 64'd0);
                check_eq("rst_wr_data", 64'(bus.wr_data), 64'd0);
            end
        end
        rdy            = m_busy();
        bus.byte_valid = ($urandom_range(99) < pct);
        bus.byte_data  = (consumed < frame.size()) ? frame[consumed] : 8'($urandom);
        start          = do_start;
        reset          = do_reset;
        exp_wr         = 1'b0;
        after_reset    = do_reset;
        if (do_reset) begin
            armed   = 1'b0;
            m_done  = 1'b0;
            m_error = 1'b0;
            m_hold  = 1'b1;
            chk_en  = 1'b1;
        end else if (bus.byte_valid && rdy) begin
            if (m_legal && consumed >= 2 && consumed < m_len + 2) begin
                exp_wr   = 1'b1;
                exp_addr = consumed - 2;
                exp_data = frame[consumed];
            end
            consumed++;
            if (consumed == total) begin
                m_done  = m_ok;
                m_error = !m_ok;
                m_hold  = !m_ok;
            end
        end else if (do_start && !rdy) begin
            frame    = next_frame;
            total    = next_total;
            m_len    = next_len;
            m_legal  = next_legal;
            m_ok     = next_ok;
            consumed = 0;
            armed    = 1'b1;
            m_done   = 1'b0;
            m_error  = 1'b0;
            m_hold   = 1'b1;
        end
    endtask

    task automatic run_load(input int pct);
        int guard = 0;
        step(1'b1, 1'b0, pct);
        while (m_busy() && guard < 2000) begin
            step($urandom_range(99) < 3, 1'b0, pct);
            guard++;
        end
        if (guard >= 2000) check_eq("load_timeout", 64'(consumed), 64'(total));
        step(1'b0, 1'b0, pct);
    endtask

    task automatic random_payload(input int n);
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
        chk_en = 1'b0; armed = 1'b0; consumed = 0; total = 0;
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        // Reference image: clean checksum is the XOR of the payload.
        pay = '{8'h93, 8'h8D, 8'h8D, 8'h3E, 8'h03, 8'h3A, 8'h84, 8'h00};
        prepare(8, pay_xor());
        run_load(100);
        check_eq("word0", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'h3E8D8D93);

        prepare(8, 8'h2C);
        run_load(100);

        random_payload(4);
        prepare(16'h005C, 8'h00);
        run_load(100);

        random_payload(6);
        prepare(6, pay_xor());
        run_load(100);

        random_payload(4);
        prepare(4, pay_xor());
        run_load(50);

        // Reset after the second payload byte, then an empty image.
        random_payload(8);
        prepare(8, pay_xor());
        step(1'b1, 1'b0, 100);
        for (int g = 0; g < 200 && consumed < 4; g++) step(1'b0, 1'b0, 100);
        step(1'b0, 1'b1, 100);
        step(1'b0, 1'b0, 0);
        pay = {};
        prepare(0, 8'h00);
        run_load(100);

        for (int f = 0; f < 25; f++) begin
            int n;
            logic [7:0] chk;
            n = ($urandom_range(7) == 0) ? int'($urandom_range(100)) : 4 * int'($urandom_range(22));
            random_payload(n);
            chk = pay_xor();
            if ($urandom_range(3) == 0) chk ^= 8'(1 + $urandom_range(254));
            prepare(n, chk);
            run_load(30 + int'($urandom_range(70)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
